// File: rtl/line_scheduler.sv
// line_scheduler
//   Chooses which function line the transformer renders (manual switches or an
//   automatic scan over 0..LINE_MAX), issues one start pulse per render, waits
//   for completion (with timeout), then dwells for DWELL_TICKS prescaler ticks
//   before the next render.
//
// Optional feature macro: LINE_SCHEDULER_BEACON_EN
//   defined     : a high `beacon` sampled in IDLE forces line BEACON_LINE
//                 (unclamped, highest priority, scan counter not advanced).
//   not defined : `beacon` is ignored and no beacon logic is built.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   ena         : scheduler runs when high (ignored while waiting on a render)
//   line_sel    : manual line index (clamped to LINE_MAX)
//   auto        : 1 = automatic scan, 0 = manual
//   rate        : prescaler period 0->2, 1->16, 2->256, 3->65536 cycles/tick
//   beacon      : beacon request (only with LINE_SCHEDULER_BEACON_EN)
//   xf_done     : one-cycle completion pulse from the transformer
//   xf_start    : one-cycle render request (high while in START)
//   line        : {2'b0, idx} to the transformer line input
//   frame       : one-cycle pulse when the auto scan wraps LINE_MAX -> 0
//   err         : sticky render-timeout flag, cleared only by reset
//   state_dbg   : current FSM state (0 IDLE, 1 START, 2 WAIT, 3 DWELL)
//
// Handshake: the transformer sees exactly one xf_start cycle per render and
// answers with one xf_done cycle; xf_done is only honoured in WAIT.
module line_scheduler #(
    parameter int LINE_MAX    = 50,
    parameter int DWELL_TICKS = 4,
    parameter int TIMEOUT     = 4096,
    parameter int BEACON_LINE = 63
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [5:0] line_sel,
    input  logic       auto,
    input  logic [1:0] rate,
    input  logic       beacon,
    input  logic       xf_done,
    output logic       xf_start,
    output logic [7:0] line,
    output logic       frame,
    output logic       err,
    output logic [1:0] state_dbg
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DWELL = 2'd3;

    localparam logic [5:0]  LINE_MAX_L   = 6'(LINE_MAX);
    localparam logic [5:0]  BEACON_L     = 6'(BEACON_LINE);
    localparam logic [7:0]  DWELL_LAST   = 8'(DWELL_TICKS - 1);
    localparam logic [15:0] TIMEOUT_L    = 16'(TIMEOUT);

    logic [1:0]  state;
    logic [5:0]  scan;
    logic [7:0]  line_r;
    logic [15:0] pre_cnt;
    logic [15:0] pre_max;
    logic [1:0]  rate_q;
    logic [7:0]  dwell_cnt;
    logic [15:0] to_cnt;
    logic [15:0] to_next;
    logic        dwell_first;
    logic        last_auto;
    logic        frame_r;
    logic        err_r;
    logic        rate_chg;
    logic        pre_clr;
    logic        tick;
    logic        use_beacon;
    logic [5:0]  sel_idx;
    logic        sel_auto;

    // ---------------- prescaler ----------------
    always_comb begin
        pre_max = 16'hFFFF;
        case (rate)
            2'd0:    pre_max = 16'd1;
            2'd1:    pre_max = 16'd15;
            2'd2:    pre_max = 16'd255;
            default: pre_max = 16'hFFFF;
        endcase
    end

    // A rate change and the first DWELL cycle both restart the count; neither
    // may produce a tick, so the dwell always spans whole tick periods.
    assign rate_chg = (rate != rate_q);
    assign pre_clr  = rate_chg || ((state == S_DWELL) && dwell_first);
    assign tick     = !pre_clr && (pre_cnt == pre_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= 16'd0;
            rate_q  <= 2'd0;
        end else begin
            rate_q <= rate;
            if (pre_clr || tick) pre_cnt <= 16'd0;
            else                 pre_cnt <= pre_cnt + 16'd1;
        end
    end

    // ---------------- line selection ----------------
`ifdef LINE_SCHEDULER_BEACON_EN
    assign use_beacon = beacon;
`else
    logic unused_beacon;
    assign unused_beacon = beacon;
    assign use_beacon    = 1'b0;
`endif

    always_comb begin
        sel_idx = line_sel;
        if (use_beacon)                sel_idx = BEACON_L;
        else if (auto)                 sel_idx = scan;
        else if (line_sel > LINE_MAX_L) sel_idx = LINE_MAX_L;
        sel_auto = auto && !use_beacon;
    end

    assign to_next = to_cnt + 16'd1;

    // ---------------- sequencer FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            line_r      <= 8'd0;
            scan        <= 6'd0;
            dwell_cnt   <= 8'd0;
            to_cnt      <= 16'd0;
            dwell_first <= 1'b0;
            last_auto   <= 1'b0;
            frame_r     <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            frame_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ena) begin
                        line_r    <= {2'b00, sel_idx};
                        last_auto <= sel_auto;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    to_cnt <= 16'd0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (xf_done) begin
                        dwell_cnt   <= 8'd0;
                        dwell_first <= 1'b1;
                        state       <= S_DWELL;
                    end else if (to_next == TIMEOUT_L) begin
                        err_r       <= 1'b1;
                        dwell_cnt   <= 8'd0;
                        dwell_first <= 1'b1;
                        state       <= S_DWELL;
                    end else begin
                        to_cnt <= to_next;
                    end
                end
                default: begin // S_DWELL
                    dwell_first <= 1'b0;
                    if (!ena) begin
                        // Abandon the dwell; the scan position is kept so the
                        // same auto line is rendered again on restart.
                        state <= S_IDLE;
                    end else if (tick) begin
                        if (dwell_cnt == DWELL_LAST) begin
                            state <= S_IDLE;
                            if (last_auto) begin
                                if (scan >= LINE_MAX_L) begin
                                    scan    <= 6'd0;
                                    frame_r <= 1'b1;
                                end else begin
                                    scan <= scan + 6'd1;
                                end
                            end
                        end else begin
                            dwell_cnt <= dwell_cnt + 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign xf_start  = (state == S_START);
    assign line      = line_r;
    assign frame     = frame_r;
    assign err       = err_r;
    assign state_dbg = state;

endmodule

// File: tb/tb_line_scheduler.sv
// Testbench for line_scheduler: directed stimulus, a transformer responder,
// and a scoreboard that pops the expected line at every xf_start pulse.
module tb_line_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [5:0] line_sel;
    logic       auto;
    logic [1:0] rate;
    logic       beacon;
    logic       xf_done = 1'b0;
    logic       xf_start;
    logic [7:0] line;
    logic       frame;
    logic       err;
    logic [1:0] state_dbg;

    line_scheduler #(
        .LINE_MAX(50), .DWELL_TICKS(4), .TIMEOUT(4096), .BEACON_LINE(63)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .line_sel(line_sel), .auto(auto),
        .rate(rate), .beacon(beacon), .xf_done(xf_done), .xf_start(xf_start),
        .line(line), .frame(frame), .err(err), .state_dbg(state_dbg)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;
    int start_cyc[$];
    int n_cmp = 0;
    int n_bad = 0;
    int frames_seen = 0;
    int frame_cyc = -1;
    int err_cyc = -1;
    logic done_en = 1'b0;
    int done_delay = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every render request is matched against the next expected line.
    always @(negedge clk) begin
        if (rst_n && xf_start) begin
            start_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL start_unexpected: got line %0d expected no render", line);
            end else begin
                exp_v = exp_q.pop_front();
                chk("start_line", {24'd0, line}, {24'd0, exp_v});
            end
        end
        if (rst_n && frame) begin
            frames_seen++;
            frame_cyc = cyc;
        end
        if (rst_n && err && err_cyc < 0) err_cyc = cyc;
    end

    // Transformer model: xf_done arrives done_delay cycles after xf_start.
    initial begin
        forever begin
            @(negedge clk);
            if (xf_start && done_en) begin
                repeat (done_delay) @(posedge clk);
                #1 xf_done = 1'b1;
                @(posedge clk);
                #1 xf_done = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Enable until n more renders have started and the last dwell has ended,
    // then drop ena in that IDLE cycle so no further render begins.
    task automatic run_renders(input int n, input string tag);
        int target;
        bit ok;
        target = start_cyc.size() + n;
        ok = 0;
        ena = 1'b1;
        for (int i = 0; i < n * 200 + 100; i++) begin
            @(posedge clk);
            #1;
            if (start_cyc.size() >= target && state_dbg == 2'd0) begin
                ok = 1;
                break;
            end
        end
        ena = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_renders: got %0d starts expected %0d", tag, start_cyc.size(), target);
        end
    endtask

    task automatic wait_start(input int base, input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (start_cyc.size() > base) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_start: got no start expected one", tag);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base;
        bit seen;
        rst_n = 1'b0; ena = 1'b0; line_sel = 6'd0; auto = 1'b0;
        rate = 2'd0; beacon = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_line", {24'd0, line}, 0);
        chk("rst_xf_start", {31'd0, xf_start}, 0);
        chk("rst_frame", {31'd0, frame}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_state", {30'd0, state_dbg}, 0);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("idle_no_start", start_cyc.size(), 0);
        chk("idle_line", {24'd0, line}, 0);
        chk("idle_state", {30'd0, state_dbg}, 0);

        // Manual line 7 at the fastest rate: 12-cycle start spacing.
        done_en = 1'b1; done_delay = 1; line_sel = 6'd7;
        base = start_cyc.size();
        repeat (3) exp_q.push_back(8'd7);
        run_renders(3, "manual7");
        chk("gap_rate0_a", start_cyc[base+1] - start_cyc[base], 12);
        chk("gap_rate0_b", start_cyc[base+2] - start_cyc[base+1], 12);

        // Out-of-range manual line clamps to LINE_MAX.
        line_sel = 6'd60;
        exp_q.push_back(8'd50);
        run_renders(1, "clamp");

        // Rate 1 (16 cycles/tick): spacing 4 + 16*4.
        rate = 2'd1; line_sel = 6'd9;
        base = start_cyc.size();
        repeat (2) exp_q.push_back(8'd9);
        run_renders(2, "rate1");
        chk("gap_rate1", start_cyc[base+1] - start_cyc[base], 68);
        rate = 2'd0;
        repeat (2) @(posedge clk);

        // Full auto scan 0..50 then wrap to 0, one frame pulse.
        auto = 1'b1;
        base = start_cyc.size();
        for (int i = 0; i <= 50; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'd0);
        run_renders(52, "scan");
        chk("frame_count", frames_seen, 1);
        chk("frame_cycle", frame_cyc, start_cyc[base+51] - 1);

        // ena dropped in WAIT: render completes; then DWELL aborts at once.
        done_delay = 5;
        base = start_cyc.size();
        exp_q.push_back(8'd1);
        #1 ena = 1'b1;
        wait_start(base, "ena_drop");
        @(posedge clk);
        #1 ena = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (state_dbg == 2'd3) begin
                seen = 1;
                break;
            end
        end
        chk("wait_completes", {31'd0, seen}, 1);
        @(posedge clk);
        #1;
        chk("dwell_abort_idle", {30'd0, state_dbg}, 0);
        done_delay = 1;
        exp_q.push_back(8'd1);     // scan counter not advanced
        run_renders(1, "after_abort");

        // Timeout: no xf_done -> err exactly TIMEOUT cycles after WAIT entry.
        done_en = 1'b0;
        base = start_cyc.size();
        exp_q.push_back(8'd2);
        ena = 1'b1;
        wait_start(base, "timeout");
        for (int i = 0; i < 5000 && err_cyc < 0; i++) @(negedge clk);
        chk("err_cycle", err_cyc, start_cyc[base] + 1 + 4096);
        done_en = 1'b1;
        exp_q.push_back(8'd3);
        run_renders(1, "after_timeout");
        chk("err_sticky", {31'd0, err}, 1);

        // Asynchronous reset during WAIT.
        done_en = 1'b0;
        base = start_cyc.size();
        exp_q.push_back(8'd4);
        ena = 1'b1;
        wait_start(base, "reset");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_line", {24'd0, line}, 0);
        chk("arst_state", {30'd0, state_dbg}, 0);
        chk("arst_err", {31'd0, err}, 0);
        chk("arst_xf_start", {31'd0, xf_start}, 0);
        ena = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        done_en = 1'b1;
        exp_q.push_back(8'd0);     // scan counter back to 0
        run_renders(1, "after_reset");

        // Beacon request during auto scan at line 1.
        beacon = 1'b1;
`ifdef LINE_SCHEDULER_BEACON_EN
        exp_q.push_back(8'd63);
`else
        exp_q.push_back(8'd1);
`endif
        run_renders(1, "beacon");
        beacon = 1'b0;
`ifdef LINE_SCHEDULER_BEACON_EN
        exp_q.push_back(8'd1);
`else
        exp_q.push_back(8'd2);
`endif
        run_renders(1, "after_beacon");

        repeat (5) @(posedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
